// File: rtl/pid_pkg.sv
// Shared types, default sizing and small helpers for the multi-channel PID controller.
package pid_pkg;

    localparam int unsigned CH_DEF    = 3;
    localparam int unsigned DW_DEF    = 16;
    localparam int unsigned GW_DEF    = 16;
    localparam int unsigned FRAC_DEF  = 6;
    localparam int unsigned ACC_W_DEF = 34;
    localparam int          INT_LIM_DEF = 8000;
    localparam int          OUT_LIM_DEF = 20000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_ERR,
        S_MP,
        S_MI,
        S_MD,
        S_OUT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        SAT_NONE = 2'd0,
        SAT_POS  = 2'd1,
        SAT_NEG  = 2'd2
    } sat_dir_t;

    // Conditional integration: hold the integrator while pushing further into saturation.
    function automatic logic windup_hold(input sat_dir_t dir, input logic e_pos, input logic e_neg);
        return ((dir == SAT_POS) && e_pos) || ((dir == SAT_NEG) && e_neg);
    endfunction

    function automatic sat_dir_t sat_dir_of(input logic clamped, input logic negative);
        if (!clamped) begin
            return SAT_NONE;
        end
        return negative ? SAT_NEG : SAT_POS;
    endfunction

endpackage

// File: rtl/pid_clamp.sv
// Combinational signed saturator from IW bits into OW bits with [LIM_LO, LIM_HI] bounds.
module pid_clamp
    import pid_pkg::*;
#(
    parameter int unsigned IW     = 17,
    parameter int unsigned OW     = 16,
    parameter longint      LIM_HI = 32767,
    parameter longint      LIM_LO = -32768
) (
    input  logic signed [IW-1:0] din,
    output logic signed [OW-1:0] dout
);

    localparam logic signed [IW-1:0] HI = IW'(LIM_HI);
    localparam logic signed [IW-1:0] LO = IW'(LIM_LO);

    always_comb begin
        dout = OW'(din);
        if (din > HI) begin
            dout = OW'(HI);
        end else if (din < LO) begin
            dout = OW'(LO);
        end
    end

endmodule

// File: rtl/pid_array.sv
// Time-multiplexed PID controller: all channels run serially through one shared multiplier,
// with error/derivative saturation, clamped anti-windup integrators and clamped outputs.
module pid_array
    import pid_pkg::*;
#(
    parameter int unsigned CH      = CH_DEF,
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned GW      = GW_DEF,
    parameter int unsigned FRAC    = FRAC_DEF,
    parameter int unsigned ACC_W   = ACC_W_DEF,
    parameter int          INT_LIM = INT_LIM_DEF,
    parameter int          OUT_LIM = OUT_LIM_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              clear_int,
    input  logic [CH*DW-1:0]  setpoint,
    input  logic [CH*DW-1:0]  measure,
    input  logic [CH*GW-1:0]  kp,
    input  logic [CH*GW-1:0]  ki,
    input  logic [CH*GW-1:0]  kd,
    output logic              busy,
    output logic              done,
    output logic [CH*DW-1:0]  out,
    output logic [CH-1:0]     sat_flags
);

    localparam int unsigned CHW = (CH > 1) ? $clog2(CH) : 1;
    localparam int unsigned PW  = DW + GW + 1;
    localparam logic [CHW-1:0] LAST_CH = CHW'(CH - 1);
    localparam longint DW_MAX = (longint'(1) << (DW - 1)) - 1;
    localparam longint DW_MIN = -(longint'(1) << (DW - 1));

    state_t state, state_nxt;
    logic [CHW-1:0] ch;
    logic           clr_req;

    logic signed [DW-1:0] sp_q   [CH];
    logic signed [DW-1:0] meas_q [CH];
    logic [GW-1:0]        kp_q   [CH];
    logic [GW-1:0]        ki_q   [CH];
    logic [GW-1:0]        kd_q   [CH];
    logic signed [DW-1:0] integ  [CH];
    logic signed [DW-1:0] prev_e [CH];
    logic signed [DW-1:0] shadow [CH];
    sat_dir_t             sat_dir[CH];

    logic signed [DW-1:0]    e_q, d_q;
    logic signed [ACC_W-1:0] acc;

    logic                 busy_nxt, done_nxt, clear_now;
    logic signed [DW-1:0] mul_a;
    logic [GW-1:0]        mul_b;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_LATCH;
            S_LATCH: state_nxt = S_ERR;
            S_ERR:   state_nxt = S_MP;
            S_MP:    state_nxt = S_MI;
            S_MI:    state_nxt = S_MD;
            S_MD:    state_nxt = S_OUT;
            S_OUT:   state_nxt = (ch == LAST_CH) ? S_DONE : S_ERR;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control decode and multiplier operand select
    always_comb begin
        busy_nxt  = (state_nxt != S_IDLE);
        done_nxt  = (state_nxt == S_DONE);
        clear_now = ((state == S_IDLE) && clear_int && !start) ||
                    ((state == S_LATCH) && clr_req);
        mul_a     = e_q;
        mul_b     = kp_q[ch];
        case (state)
            S_MI: begin
                mul_a = integ[ch];
                mul_b = ki_q[ch];
            end
            S_MD: begin
                mul_a = d_q;
                mul_b = kd_q[ch];
            end
            default: ;
        endcase
    end

    // Error, derivative and integrator candidate for the current channel
    logic signed [DW:0]   e_wide, d_wide, i_wide;
    logic signed [DW-1:0] e_sat, d_sat, i_cand;
    logic                 e_pos, e_neg;

    assign e_wide = (DW+1)'(sp_q[ch]) - (DW+1)'(meas_q[ch]);
    assign d_wide = (DW+1)'(e_sat) - (DW+1)'(prev_e[ch]);
    assign i_wide = (DW+1)'(integ[ch]) + (DW+1)'(e_sat);
    assign e_neg  = e_sat[DW-1];
    assign e_pos  = !e_sat[DW-1] && (e_sat != '0);

    pid_clamp #(.IW(DW+1), .OW(DW), .LIM_HI(DW_MAX), .LIM_LO(DW_MIN)) u_err_sat (
        .din  (e_wide),
        .dout (e_sat)
    );

    pid_clamp #(.IW(DW+1), .OW(DW), .LIM_HI(DW_MAX), .LIM_LO(DW_MIN)) u_der_sat (
        .din  (d_wide),
        .dout (d_sat)
    );

    pid_clamp #(.IW(DW+1), .OW(DW), .LIM_HI(INT_LIM), .LIM_LO(-INT_LIM)) u_int_clamp (
        .din  (i_wide),
        .dout (i_cand)
    );

    // Shared signed-by-unsigned multiplier; gains are zero-extended
    logic signed [PW-1:0] mul_a_x, mul_b_x, prod;

    assign mul_a_x = PW'(mul_a);
    assign mul_b_x = $signed(PW'(mul_b));
    assign prod    = mul_a_x * mul_b_x;

    // Output scaling and clamp; a clamp is detected as the result differing from y
    logic signed [ACC_W-1:0] y;
    logic signed [DW-1:0]    yo;
    logic                    y_clamped;

    assign y         = acc >>> FRAC;
    assign y_clamped = (ACC_W'(yo) != y);

    pid_clamp #(.IW(ACC_W), .OW(DW), .LIM_HI(OUT_LIM), .LIM_LO(-OUT_LIM)) u_out_clamp (
        .din  (y),
        .dout (yo)
    );

    // Complete output vector, with the last channel bypassing its shadow slot
    logic [CH*DW-1:0] out_nxt;
    logic [CH-1:0]    sat_nxt;

    always_comb begin
        out_nxt = '0;
        sat_nxt = '0;
        for (int i = 0; i < CH; i++) begin
            if (CHW'(i) == ch) begin
                out_nxt[i*DW +: DW] = yo;
                sat_nxt[i]          = y_clamped;
            end else begin
                out_nxt[i*DW +: DW] = shadow[i];
                sat_nxt[i]          = (sat_dir[i] != SAT_NONE);
            end
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            out       <= '0;
            sat_flags <= '0;
            ch        <= '0;
            clr_req   <= 1'b0;
            e_q       <= '0;
            d_q       <= '0;
            acc       <= '0;
            for (int i = 0; i < CH; i++) begin
                sp_q[i]    <= '0;
                meas_q[i]  <= '0;
                kp_q[i]    <= '0;
                ki_q[i]    <= '0;
                kd_q[i]    <= '0;
                integ[i]   <= '0;
                prev_e[i]  <= '0;
                shadow[i]  <= '0;
                sat_dir[i] <= SAT_NONE;
            end
        end else begin
            busy <= busy_nxt;
            done <= done_nxt;
            if (state == S_IDLE) begin
                clr_req <= start && clear_int;
            end
            if (clear_now) begin
                for (int i = 0; i < CH; i++) begin
                    integ[i]   <= '0;
                    prev_e[i]  <= '0;
                    sat_dir[i] <= SAT_NONE;
                end
            end
            case (state)
                S_LATCH: begin
                    ch <= '0;
                    for (int i = 0; i < CH; i++) begin
                        sp_q[i]   <= setpoint[i*DW +: DW];
                        meas_q[i] <= measure[i*DW +: DW];
                        kp_q[i]   <= kp[i*GW +: GW];
                        ki_q[i]   <= ki[i*GW +: GW];
                        kd_q[i]   <= kd[i*GW +: GW];
                    end
                end
                S_ERR: begin
                    e_q        <= e_sat;
                    d_q        <= d_sat;
                    prev_e[ch] <= e_sat;
                    acc        <= '0;
                    if (!windup_hold(sat_dir[ch], e_pos, e_neg)) begin
                        integ[ch] <= i_cand;
                    end
                end
                S_MP, S_MI, S_MD: begin
                    acc <= acc + ACC_W'(prod);
                end
                S_OUT: begin
                    shadow[ch]  <= yo;
                    sat_dir[ch] <= sat_dir_of(y_clamped, y[ACC_W-1]);
                    if (ch == LAST_CH) begin
                        out       <= out_nxt;
                        sat_flags <= sat_nxt;
                    end else begin
                        ch <= ch + CHW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
